// File: rtl/mcu_multiport_pkg.sv
// Shared types and encodings for the multi-port memory control unit.
package mcu_multiport_pkg;

  // Transfer sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Transfer size codes carried on size_in
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // RAM direction encodings
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Index of the final beat for a size code; a word is the full NB bytes.
  function automatic int last_beat(input logic [1:0] size, input int nb);
    if (size == SZ_BYTE) return 0;
    else if (size == SZ_HALF) return (nb >= 2) ? 1 : 0;
    else return nb - 1;
  endfunction

endpackage

// File: rtl/mcu_multiport_arbiter.sv
// Request arbiter: picks one requester, fixed priority or round-robin from ptr_i+1.
module mcu_arbiter #(
  parameter int N_PORTS = 2,
  parameter int RR_MODE = 0,
  parameter int IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [N_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_valid_o
);

  logic [IDX_W-1:0] cand;

  // Walk candidates in priority order and keep the first one that requests
  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand        = '0;
    for (int off = 1; off <= N_PORTS; off++) begin
      if (RR_MODE != 0) cand = IDX_W'((int'(ptr_i) + off) % N_PORTS);
      else              cand = IDX_W'(off - 1);
      if (!gnt_valid_o && req_i[cand]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = cand;
      end
    end
    if (gnt_valid_o) gnt_o[gnt_idx_o] = 1'b1;
  end

endmodule

// File: rtl/mcu_multiport.sv
// Multi-port memory control unit: arbitrates N_PORTS requesters onto a byte-serial RAM port.
// Handshake: a port raises req_in and holds its request fields; the request is latched at the
// grant and done_out pulses for one cycle when the transfer is finished, after which the port
// may drop req_in. rdy low only suppresses new grants.
module mcu_multiport
  import mcu_multiport_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_MODE = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic [N_PORTS-1:0]          req_in,
  input  logic [N_PORTS-1:0]          we_in,
  input  logic [N_PORTS*ADDR_W-1:0]   addr_in,
  input  logic [N_PORTS*DATA_W-1:0]   wdata_in,
  input  logic [2*N_PORTS-1:0]        size_in,
  output logic [DATA_W-1:0]           rdata_out,
  output logic [N_PORTS-1:0]          done_out,
  output logic [N_PORTS-1:0]          stall_out,
  input  logic [7:0]                  ma_data_in,
  output logic [ADDR_W-1:0]           ma_addr_out,
  output logic [7:0]                  ma_data_out,
  output logic                        ma_rw_out,
  output logic                        ma_ce_out,
  output logic [1:0]                  dbg_state_o
);

  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q, last_q;
  logic                we_q;
  logic [ADDR_W-1:0]   ma_addr_q;
  logic [DATA_W-1:0]   wsh_q, rdata_q;
  logic [N_PORTS-1:0]  gnt_oh_q, done_q;
  logic [IDX_W-1:0]    ptr_q;
  logic                ce_q, rw_q;

  logic [N_PORTS-1:0]  arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_valid;

  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [1:0]          sel_size;
  logic [CNT_W-1:0]    sel_last;
  logic [CNT_W-1:0]    rd_idx;

  mcu_arbiter #(
    .N_PORTS (N_PORTS),
    .RR_MODE (RR_MODE),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i       (req_in),
    .ptr_i       (ptr_q),
    .gnt_o       (arb_gnt),
    .gnt_idx_o   (arb_idx),
    .gnt_valid_o (arb_valid)
  );

  // Mux out the winning port's request fields and pick the byte lane being captured
  always_comb begin
    sel_we    = we_in[arb_idx];
    sel_addr  = addr_in[arb_idx*ADDR_W +: ADDR_W];
    sel_wdata = wdata_in[arb_idx*DATA_W +: DATA_W];
    sel_size  = size_in[arb_idx*2 +: 2];
    sel_last  = CNT_W'(last_beat(sel_size, NB));
    // RAM data lags its address by one cycle, so capture the previous beat's byte
    rd_idx    = (state_q == ST_DRAIN) ? last_q : (cnt_q - 1'b1);
  end

  // Transfer FSM with registered RAM-side outputs and completion pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_q    <= '0;
      we_q      <= RW_READ;
      ma_addr_q <= '0;
      wsh_q     <= '0;
      rdata_q   <= '0;
      gnt_oh_q  <= '0;
      done_q    <= '0;
      ptr_q     <= IDX_W'(N_PORTS - 1);
      ce_q      <= 1'b0;
      rw_q      <= RW_READ;
    end else begin
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (rdy && arb_valid) begin
            state_q   <= ST_XFER;
            cnt_q     <= '0;
            last_q    <= sel_last;
            we_q      <= sel_we;
            ma_addr_q <= sel_addr;
            wsh_q     <= sel_wdata;
            rdata_q   <= '0;
            gnt_oh_q  <= arb_gnt;
            ptr_q     <= arb_idx;
            ce_q      <= 1'b1;
            rw_q      <= sel_we;
          end
        end
        ST_XFER: begin
          if (we_q == RW_READ && cnt_q != '0) rdata_q[8*rd_idx +: 8] <= ma_data_in;
          if (cnt_q == last_q) begin
            ce_q <= 1'b0;
            rw_q <= RW_READ;
            if (we_q == RW_WRITE) begin
              state_q <= ST_DONE;
              done_q  <= gnt_oh_q;
            end else begin
              state_q <= ST_DRAIN;
            end
          end else begin
            cnt_q     <= cnt_q + 1'b1;
            ma_addr_q <= ma_addr_q + 1'b1;
            wsh_q     <= wsh_q >> 8;
          end
        end
        ST_DRAIN: begin
          rdata_q[8*rd_idx +: 8] <= ma_data_in;
          state_q                <= ST_DONE;
          done_q                 <= gnt_oh_q;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ma_addr_out = ma_addr_q;
  assign ma_data_out = wsh_q[7:0];
  assign ma_rw_out   = rw_q;
  assign ma_ce_out   = ce_q;
  assign rdata_out   = rdata_q;
  assign done_out    = done_q;
  assign stall_out   = req_in & ~done_q;
  assign dbg_state_o = state_q;

endmodule
